psum_drain: RTL and testbench
=============================

Name: psum_drain

Overview:
- Sits at the bottom of each fusion-unit column and consumes the packed partial sums forwarded out of the last row.
- Unpacks the packed word into 1, 2 or 4 lanes according to the weight precision mode, then sign- or zero-extends each lane.
- Accumulates over a programmable number of beats per result and buffers finished results in a small FIFO.
- Results leave through a valid/ready stream toward the output buffer.

Parameters:
- COL_WIDTH, 13: per-lane width in 2b/1b mode; the packed input is 4*COL_WIDTH bits.
- ACC_WIDTH, 64: per-lane accumulator width; must be >= 4*COL_WIDTH.
- FIFO_DEPTH, 4: number of result entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run, sampled only in IDLE.
- weight_width  in  4  precision code, sampled at start: 4'b1000=8b, 4'b0100=4b, 4'b00zz=2b/1b.
- signed_mode  in  1  sampled at start; 1 = sign-extend lanes.
- acc_len  in  8  beats per result, sampled at start.
- num_groups  in  8  results per run, sampled at start.
- psum_valid  in  1  packed psum beat present.
- psum_ready  out  1  beat accepted when psum_valid && psum_ready.
- psum_in  in  4*COL_WIDTH  packed partial sum.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  4*ACC_WIDTH  lane k at bits [k*ACC_WIDTH +: ACC_WIDTH].
- out_lanes  out  2  0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes.
- busy  out  1  state != IDLE or FIFO non-empty.
- cfg_err  out  1  sticky illegal-configuration flag.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, FIFO empty, accumulators and beat/group counters 0. All outputs are 0: psum_ready, out_valid, out_data, out_lanes, busy, cfg_err.
- Reset asserted mid-run discards all partial sums and buffered results.
- FSM states are IDLE, ACCUM, FLUSH.
- IDLE:
  - start with a legal configuration latches the configuration, clears the accumulators and cfg_err, and moves to ACCUM.
  - The configuration is illegal if weight_width is not 1000, 0100 or 00zz, or acc_len == 0, or num_groups == 0.
  - start with an illegal configuration sets cfg_err and the block stays in IDLE.
  - start outside IDLE is ignored.
- ACCUM:
  - psum_ready = !fifo_full. The full flag is evaluated before a same-cycle pop, so a pop on a full FIFO does not allow a push in the same cycle.
  - Each accepted beat adds the unpacked lanes to the accumulators, modulo 2^ACC_WIDTH (wrap, no saturation).
- Unpacking by mode:
  - 8b: lane0 = psum_in[4C-1:0]; lanes 1-3 are 0.
  - 4b: lane0 = [2C-1:0], lane1 = [4C-1:2C]; lanes 2-3 are 0.
  - 2b/1b: lane k = [(k+1)C-1:kC] for k = 0..3.
  - Here C = COL_WIDTH. Extension uses the lane MSB if signed_mode = 1, zeros otherwise.
- On the acc_len-th accepted beat:
  - Accumulator + current lanes are pushed to the FIFO together with out_lanes; unused lanes are stored as 0.
  - Accumulators and the beat counter clear the next cycle; the group counter increments.
  - After the num_groups-th push the FSM goes to FLUSH.
- FLUSH: psum_ready = 0; go to IDLE when the FIFO is empty.
- Latency: result visible on out_valid the cycle after its last beat is accepted.
- Output stream:
  - out_data and out_lanes show the FIFO head while out_valid = 1, and are 0 otherwise.
  - Pop on out_valid && out_ready.
  - Results leave in push order.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.

Test Plan:
- 8b unsigned, acc_len=3, num_groups=1; beats 100, 200, 300 -> out_valid one cycle after beat 3, lane0=600, other lanes 0, out_lanes=0; busy drops after the pop.
- 4b signed, acc_len=2; both beats lane0 = 26'h3FFFFFB (-5), lane1 = 7 -> lane0 = 64'hFFFFFFFFFFFFFFF6, lane1 = 14, out_lanes=1.
- 2b signed, acc_len=1; lanes = 13'h1FFF, 13'h0001, 13'h1000, 13'h0FFF -> -1, 1, -4096, 4095 sign-extended to 64 bits, out_lanes=2.
- acc_len=1, num_groups=6, out_ready=0 -> after 4 results psum_ready=0 and holds. Raise out_ready -> all 6 results appear in order, FLUSH then IDLE.
- start with weight_width=4'b0110 -> cfg_err=1, busy=0, no beats accepted. Then a legal start -> cfg_err clears and the run proceeds.
- rst_n pulsed low during ACCUM with 2 FIFO entries -> out_valid=0, psum_ready=0, busy=0 immediately. The next run's first result excludes the pre-reset sums.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: drains packed partial sums from the bottom of a fusion-unit
// column. Each beat is split into 1, 2 or 4 lanes according to the weight
// precision. Each lane is sign- or zero-extended and summed over acc_len beats.
// Finished results are queued in a small FIFO and leave on a valid/ready
// stream.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start                     run start pulse (sampled in IDLE only)
//   weight_width, signed_mode precision code and extension mode, sampled at start
//   acc_len, num_groups       beats per result / results per run, sampled at start
//   psum_valid/psum_ready     packed partial-sum input handshake
//   psum_in                   packed partial sum, 4*COL_WIDTH bits
//   out_valid/out_ready       result stream handshake
//   out_data                  lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   out_lanes                 0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes
//   busy                      run in progress or results still buffered
//   cfg_err                   sticky illegal-configuration flag
module psum_drain #(
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               weight_width,
  input  logic                     signed_mode,
  input  logic [7:0]               acc_len,
  input  logic [7:0]               num_groups,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [4*COL_WIDTH-1:0]   psum_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*ACC_WIDTH-1:0]   out_data,
  output logic [1:0]               out_lanes,
  output logic                     busy,
  output logic                     cfg_err
);
  localparam int PW = 4 * COL_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   mode_q, mode_d;
  logic                         sgn_q, sgn_d;
  logic [7:0]                   len_q, len_d, ngrp_q, ngrp_d;
  logic [7:0]                   beat_q, beat_d, grp_q, grp_d;
  logic [3:0][ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                         cfg_err_q, cfg_err_d;
  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                  cnt_q, cnt_d;
  logic [4*ACC_WIDTH-1:0]       mem_data [FIFO_DEPTH];
  logic [1:0]                   mem_lanes [FIFO_DEPTH];

  logic                         cfg_legal;
  logic [1:0]                   cfg_mode;
  logic                         full, accept, last_beat, push, pop;
  logic [3:0][ACC_WIDTH-1:0]    lanes, sum;

  // Extend a lane occupying raw[w-1:0] (upper raw bits already zero).
  function automatic logic [ACC_WIDTH-1:0] extend(input logic [PW-1:0] raw,
                                                  input int w, input logic msb);
    logic [ACC_WIDTH-1:0] r;
    r = ACC_WIDTH'(raw);
    for (int i = 0; i < ACC_WIDTH; i++)
      if (i >= w) r[i] = msb;
    return r;
  endfunction

  function automatic logic [3:0][ACC_WIDTH-1:0] unpack(input logic [PW-1:0] p,
                                                       input logic [1:0] mode,
                                                       input logic sgn);
    logic [3:0][ACC_WIDTH-1:0] l;
    l = '0;
    case (mode)
      2'd0: l[0] = extend(p, PW, sgn & p[PW-1]);
      2'd1: begin
        l[0] = extend({{(PW/2){1'b0}}, p[PW/2-1:0]}, PW/2, sgn & p[PW/2-1]);
        l[1] = extend({{(PW/2){1'b0}}, p[PW-1:PW/2]}, PW/2, sgn & p[PW-1]);
      end
      default: begin
        for (int k = 0; k < 4; k++)
          l[k] = extend({{(PW-COL_WIDTH){1'b0}}, p[k*COL_WIDTH +: COL_WIDTH]},
                        COL_WIDTH, sgn & p[k*COL_WIDTH+COL_WIDTH-1]);
      end
    endcase
    return l;
  endfunction

  // Configuration decode; mode doubles as the out_lanes code.
  always_comb begin
    cfg_mode  = 2'd2;
    cfg_legal = 1'b1;
    if (weight_width == 4'b1000)      cfg_mode = 2'd0;
    else if (weight_width == 4'b0100) cfg_mode = 2'd1;
    else if (weight_width[3:2] != 2'b00) cfg_legal = 1'b0;
    if (acc_len == 8'd0 || num_groups == 8'd0) cfg_legal = 1'b0;
  end

  // Full is taken from the registered count, so a pop on a full FIFO
  // cannot make room for a push in the same cycle.
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign accept    = psum_valid && psum_ready;
  assign last_beat = (beat_q == len_q - 8'd1);
  assign push      = accept && last_beat;
  assign pop       = out_valid && out_ready;
  assign lanes     = unpack(psum_in, mode_q, sgn_q);

  always_comb begin
    for (int k = 0; k < 4; k++) sum[k] = acc_q[k] + lanes[k];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && cfg_legal) state_d = S_ACCUM;
      S_ACCUM: if (push && grp_q == ngrp_q - 8'd1) state_d = S_FLUSH;
      S_FLUSH: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    psum_ready = (state_q == S_ACCUM) && !full;
    out_valid  = (cnt_q != '0);
    busy       = (state_q != S_IDLE) || (cnt_q != '0);
    cfg_err    = cfg_err_q;
    out_data   = out_valid ? mem_data[rd_q] : '0;
    out_lanes  = out_valid ? mem_lanes[rd_q] : 2'd0;
  end

  // Datapath / counter next state
  always_comb begin
    mode_d    = mode_q;
    sgn_d     = sgn_q;
    len_d     = len_q;
    ngrp_d    = ngrp_q;
    beat_d    = beat_q;
    grp_d     = grp_q;
    acc_d     = acc_q;
    cfg_err_d = cfg_err_q;
    if (state_q == S_IDLE && start) begin
      if (cfg_legal) begin
        mode_d    = cfg_mode;
        sgn_d     = signed_mode;
        len_d     = acc_len;
        ngrp_d    = num_groups;
        beat_d    = 8'd0;
        grp_d     = 8'd0;
        acc_d     = '0;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
    if (accept) begin
      if (last_beat) begin
        acc_d  = '0;
        beat_d = 8'd0;
        grp_d  = grp_q + 8'd1;
      end else begin
        acc_d  = sum;
        beat_d = beat_q + 8'd1;
      end
    end
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'd0;
      sgn_q     <= 1'b0;
      len_q     <= 8'd0;
      ngrp_q    <= 8'd0;
      beat_q    <= 8'd0;
      grp_q     <= 8'd0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      sgn_q     <= sgn_d;
      len_q     <= len_d;
      ngrp_q    <= ngrp_d;
      beat_q    <= beat_d;
      grp_q     <= grp_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  // Result storage; unused lanes hold zero because their accumulators and
  // unpacked inputs stay zero for the whole run.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_q]  <= sum;
      mem_lanes[wr_q] <= mode_q;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
`timescale 1ns/1ps
module tb_psum_drain;
  localparam int C  = 13;
  localparam int A  = 64;
  localparam int PW = 4 * C;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      weight_width = 4'b1000;
  logic            signed_mode = 1'b0;
  logic [7:0]      acc_len = 8'd1;
  logic [7:0]      num_groups = 8'd1;
  logic            psum_valid = 1'b0;
  logic            psum_ready;
  logic [PW-1:0]   psum_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4*A-1:0]  out_data;
  logic [1:0]      out_lanes;
  logic            busy;
  logic            cfg_err;

  psum_drain #(.COL_WIDTH(C), .ACC_WIDTH(A), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight_width(weight_width),
    .signed_mode(signed_mode), .acc_len(acc_len), .num_groups(num_groups),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lanes(out_lanes), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*A-1:0] data;
    logic [1:0]     lanes;
  } res_t;

  res_t        expq[$];
  res_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          m_nl = 1;
  int          m_len = 1;
  int          m_beat = 0;
  logic        m_sgn = 1'b0;
  logic [A-1:0] m_acc [4];
  logic        rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [4*A-1:0] obs, input logic [4*A-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: split the word into equal-width lanes, extend with
  // arithmetic, sum, and emit one expected result every m_len beats.
  task automatic model_beat(input logic [PW-1:0] d);
    int w;
    logic [A-1:0] raw, v, full_w;
    res_t r;
    w = PW / m_nl;
    full_w = 64'd1 << w;
    for (int k = 0; k < m_nl; k++) begin
      raw = (64'(d) >> (k * w)) & (full_w - 64'd1);
      v = raw;
      if (m_sgn && raw[w-1]) v = raw - full_w;
      m_acc[k] = m_acc[k] + v;
    end
    m_beat++;
    if (m_beat == m_len) begin
      r.data = '0;
      for (int k = 0; k < 4; k++) r.data[k*A +: A] = m_acc[k];
      r.lanes = (m_nl == 1) ? 2'd0 : (m_nl == 2) ? 2'd1 : 2'd2;
      expq.push_back(r);
      for (int k = 0; k < 4; k++) m_acc[k] = '0;
      m_beat = 0;
    end
  endtask

  task automatic do_start(input logic [3:0] ww, input logic sg,
                          input logic [7:0] len, input logic [7:0] ng);
    weight_width = ww; signed_mode = sg; acc_len = len; num_groups = ng;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if ((ww == 4'b1000 || ww == 4'b0100 || ww[3:2] == 2'b00) && len != 0 && ng != 0) begin
      m_nl  = (ww == 4'b1000) ? 1 : (ww == 4'b0100) ? 2 : 4;
      m_sgn = sg;
      m_len = int'(len);
      m_beat = 0;
      for (int k = 0; k < 4; k++) m_acc[k] = '0;
    end
  endtask

  task automatic send_beat(input logic [PW-1:0] d);
    int n;
    n = 0;
    psum_valid = 1'b1;
    psum_in = d;
    @(negedge clk);
    while (!psum_ready && n < 100) begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n++;
    end
    chk("beat_accepted", (n < 100), 1'b1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
    if (n < 100) model_beat(d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_drained"}, expq.size(), 0);
    out_ready = 1'b0;
  endtask

  // Result monitor: every popped head must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("res_present", (expq.size() != 0), 1'b1);
      if (expq.size() != 0) begin
        mon_e = expq.pop_front();
        chk("res_data", out_data, mon_e.data);
        chk("res_lanes", out_lanes, mon_e.lanes);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] d;
    logic [3:0]    wws [6];
    int            len, ng;
    wws[0] = 4'b1000; wws[1] = 4'b0100; wws[2] = 4'b0000;
    wws[3] = 4'b0001; wws[4] = 4'b0010; wws[5] = 4'b0011;
    for (int k = 0; k < 4; k++) m_acc[k] = '0;

    // reset state
    #2;
    chk("rst_psum_ready", psum_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_lanes", out_lanes, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 8b unsigned, three beats
    do_start(4'b1000, 1'b0, 8'd3, 8'd1);
    chk("t1_busy", busy, 1'b1);
    send_beat(PW'(100));
    send_beat(PW'(200));
    chk("t1_no_early", out_valid, 1'b0);
    send_beat(PW'(300));
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_lane0", out_data[A-1:0], 64'd600);
    chk("t1_upper", out_data[4*A-1:A], '0);
    chk("t1_lanes", out_lanes, 2'd0);
    wait_idle("t1");

    // 4b signed
    do_start(4'b0100, 1'b1, 8'd2, 8'd1);
    send_beat({26'd7, 26'h3FFFFFB});
    send_beat({26'd7, 26'h3FFFFFB});
    chk("t2_lane0", out_data[A-1:0], 64'hFFFFFFFFFFFFFFF6);
    chk("t2_lane1", out_data[2*A-1:A], 64'd14);
    chk("t2_lanes", out_lanes, 2'd1);
    wait_idle("t2");

    // 2b signed, lane boundaries
    do_start(4'b0001, 1'b1, 8'd1, 8'd1);
    send_beat({13'h0FFF, 13'h1000, 13'h0001, 13'h1FFF});
    chk("t3_lane0", out_data[A-1:0], 64'hFFFFFFFFFFFFFFFF);
    chk("t3_lane1", out_data[2*A-1:A], 64'd1);
    chk("t3_lane2", out_data[3*A-1:2*A], 64'hFFFFFFFFFFFFF000);
    chk("t3_lane3", out_data[4*A-1:3*A], 64'd4095);
    chk("t3_lanes", out_lanes, 2'd2);
    wait_idle("t3");

    // backpressure: FIFO fills after four results
    do_start(4'b0010, 1'b0, 8'd1, 8'd6);
    for (int i = 0; i < 4; i++) send_beat(PW'({$urandom, $urandom}));
    psum_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_held", psum_ready, 1'b0);
    end
    chk("t4_full_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) send_beat(PW'({$urandom, $urandom}));
    wait_idle("t4");

    // illegal configurations
    do_start(4'b0110, 1'b0, 8'd1, 8'd1);
    chk("t5_cfg_err", cfg_err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    psum_valid = 1'b1;
    @(negedge clk);
    chk("t5_no_accept", psum_ready, 1'b0);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    do_start(4'b1000, 1'b0, 8'd0, 8'd1);
    chk("t5_len0_err", cfg_err, 1'b1);
    chk("t5_len0_busy", busy, 1'b0);
    do_start(4'b0100, 1'b0, 8'd1, 8'd1);
    chk("t5_cfg_clear", cfg_err, 1'b0);
    chk("t5_run_busy", busy, 1'b1);
    send_beat(PW'({$urandom, $urandom}));
    wait_idle("t5");

    // reset in the middle of a run
    do_start(4'b1000, 1'b0, 8'd2, 8'd4);
    for (int i = 0; i < 5; i++) send_beat(PW'(1000 + i));
    chk("t6_pending", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_psum_ready", psum_ready, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_out_data", out_data, '0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(4'b1000, 1'b0, 8'd1, 8'd1);
    send_beat(PW'(5));
    chk("t6_fresh", out_data[A-1:0], 64'd5);
    wait_idle("t6");

    // randomized runs with random consumer stalls
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 4);
      ng  = $urandom_range(1, 5);
      do_start(wws[$urandom_range(0, 5)], ($urandom_range(0, 1) == 1), 8'(len), 8'(ng));
      rnd_rdy = 1'b1;
      for (int b = 0; b < len * ng; b++) begin
        d = PW'({$urandom, $urandom});
        send_beat(d);
      end
      rnd_rdy = 1'b0;
      wait_idle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
